// File: rtl/crc_pkg.sv
// Shared definitions for the CRC stream engine: default sizes, common presets and FSM encoding.
package crc_pkg;

    localparam int CRC_MAX_W = 16;
    localparam int CRC_DW    = 8;

    localparam logic [15:0] CRC5_EPC_POLY     = 16'h0009;
    localparam logic [15:0] CRC5_EPC_INIT     = 16'h0009;
    localparam logic [15:0] CRC8_SMBUS_POLY   = 16'h0007;
    localparam logic [15:0] CRC16_XMODEM_POLY = 16'h1021;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } crc_state_e;

    // Out-of-range widths (0 or above the register size) collapse to the full register.
    function automatic logic [4:0] eff_width(input logic [4:0] w, input int max_w);
        if (w == 5'd0 || int'(w) > max_w) return 5'(max_w);
        return w;
    endfunction

endpackage

// File: rtl/crc_stream_engine_if.sv
// Stream handshake bundle between the framer (master) and the CRC engine (slave).
interface crc_stream_engine_if #(
    parameter int MAX_W = 16,
    parameter int DW    = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [MAX_W-1:0] out_crc;
    logic             out_ok;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_crc, out_ok
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_crc, out_ok
    );
endinterface

// File: rtl/crc_nstep.sv
// Combinational DW-bit unrolled CRC update, MSB-first, for a runtime width and polynomial.
module crc_nstep #(
    parameter int MAX_W = 16,
    parameter int DW    = 8
) (
    input  logic [MAX_W-1:0] r_in,
    input  logic [DW-1:0]    data,
    input  logic [4:0]       width,
    input  logic [MAX_W-1:0] poly,
    output logic [MAX_W-1:0] r_out
);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] top;
    logic [MAX_W-1:0] r;
    logic             fb;

    always_comb begin
        mask = '0;
        top  = '0;
        for (int j = 0; j < MAX_W; j++) begin
            mask[j] = (j < int'(width));
            top[j]  = (j == int'(width) - 1);
        end
        r  = r_in & mask;
        fb = 1'b0;
        // top selects bit W-1 so the feedback tap follows the runtime width.
        for (int i = DW - 1; i >= 0; i--) begin
            fb = (|(r & top)) ^ data[i];
            r  = ((r << 1) ^ (fb ? poly : '0)) & mask;
        end
        r_out = r;
    end
endmodule

// File: rtl/crc_stream_engine.sv
// Framed-stream CRC engine: per-frame latched config, one registered result slot.
// Optional residue checking on RX is enabled by defining CRC_CHECK_EN.
module crc_stream_engine
    import crc_pkg::*;
#(
    parameter int MAX_W = CRC_MAX_W,
    parameter int DW    = CRC_DW
) (
    input  logic             clk,
    input  logic             rst_n,
    crc_stream_engine_if.slave s,
    input  logic [4:0]       cfg_width,
    input  logic [MAX_W-1:0] cfg_poly,
    input  logic [MAX_W-1:0] cfg_init,
    input  logic [MAX_W-1:0] cfg_xorout
`ifdef CRC_CHECK_EN
    ,input logic [MAX_W-1:0] cfg_residue
`endif
);
    // state | meaning
    // IDLE  | no frame in progress, no result pending
    // BUSY  | mid-frame, crc_q holds the running remainder
    // DONE  | result presented on out_crc, waiting for out_ready

    crc_state_e       state_q, state_d;
    logic [MAX_W-1:0] crc_q;
    logic [4:0]       width_q;
    logic [MAX_W-1:0] poly_q, xorout_q;
    logic [MAX_W-1:0] out_crc_q;

    logic             accept, first;
    logic [4:0]       width_use;
    logic [MAX_W-1:0] poly_use, xorout_use, mask_use;
    logic [MAX_W-1:0] r_start, r_next, crc_fin;

    assign s.out_valid = (state_q == DONE);
    assign s.in_ready  = (state_q != DONE) || s.out_ready;
    assign s.out_crc   = out_crc_q;
    assign accept      = s.in_valid && s.in_ready;
    // Any beat not taken in BUSY opens a new frame and reloads the config.
    assign first       = (state_q != BUSY);

    assign width_use  = first ? eff_width(cfg_width, MAX_W) : width_q;
    assign poly_use   = first ? cfg_poly   : poly_q;
    assign xorout_use = first ? cfg_xorout : xorout_q;
    assign r_start    = first ? cfg_init   : crc_q;

    always_comb begin
        mask_use = '0;
        for (int j = 0; j < MAX_W; j++) mask_use[j] = (j < int'(width_use));
    end

    crc_nstep #(.MAX_W(MAX_W), .DW(DW)) u_nstep (
        .r_in  (r_start),
        .data  (s.in_data),
        .width (width_use),
        .poly  (poly_use & mask_use),
        .r_out (r_next)
    );

    assign crc_fin = (r_next ^ xorout_use) & mask_use;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, BUSY: if (accept) state_d = s.in_last ? DONE : BUSY;
            DONE: begin
                if (accept)           state_d = s.in_last ? DONE : BUSY;
                else if (s.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            crc_q     <= '0;
            width_q   <= '0;
            poly_q    <= '0;
            xorout_q  <= '0;
            out_crc_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                crc_q <= r_next;
                if (first) begin
                    width_q  <= width_use;
                    poly_q   <= cfg_poly;
                    xorout_q <= cfg_xorout;
                end
                if (s.in_last) out_crc_q <= crc_fin;
            end
        end
    end

`ifdef CRC_CHECK_EN
    logic [MAX_W-1:0] residue_q, residue_use;
    logic             out_ok_q;

    assign residue_use = first ? cfg_residue : residue_q;
    assign s.out_ok    = out_ok_q;

    // Residue compares the raw remainder, before the output XOR mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            residue_q <= '0;
            out_ok_q  <= 1'b0;
        end else if (accept) begin
            if (first)     residue_q <= cfg_residue;
            if (s.in_last) out_ok_q  <= (r_next == (residue_use & mask_use));
        end
    end
`else
    assign s.out_ok = 1'b0;
`endif

endmodule

// File: tb/tb_crc_stream_engine.sv
// Scoreboard bench for crc_stream_engine: driver pushes expected CRCs, negedge monitor pops and compares.
module tb_crc_stream_engine;
    import crc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  cfg_width = '0;
    logic [15:0] cfg_poly = '0, cfg_init = '0, cfg_xorout = '0, cfg_residue = '0;

    int total = 0;
    int bad   = 0;

    logic [15:0] sb_crc[$];
    logic        sb_ok[$];
    logic [7:0]  frm[$];

    crc_stream_engine_if #(.MAX_W(16), .DW(8)) sif ();

    crc_stream_engine #(.MAX_W(16), .DW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s          (sif.slave),
        .cfg_width  (cfg_width),
        .cfg_poly   (cfg_poly),
        .cfg_init   (cfg_init),
        .cfg_xorout (cfg_xorout)
`ifdef CRC_CHECK_EN
        ,.cfg_residue (cfg_residue)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic load_check_string();
        frm = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    endtask

    // Returns at posedge+1 after the beat is accepted.
    task automatic drive_beat(input logic [7:0] d, input logic last);
        logic rdy;
        int   n;
        n = 0;
        @(negedge clk);
        sif.in_valid = 1'b1;
        sif.in_data  = d;
        sif.in_last  = last;
        forever begin
            #4 rdy = sif.in_ready;
            @(posedge clk);
            if (rdy) break;
            n++;
            if (n > 200) begin
                chk("beat_timeout", 32'(n), 32'd0);
                break;
            end
            @(negedge clk);
        end
        #1;
    endtask

    task automatic send_frame(input logic [4:0] w, input logic [15:0] poly, input logic [15:0] init,
                              input logic [15:0] xo, input logic [15:0] res,
                              input logic [15:0] ec, input logic eo, input bit garble);
        sb_crc.push_back(ec);
        sb_ok.push_back(eo);
        cfg_width   = w;
        cfg_poly    = poly;
        cfg_init    = init;
        cfg_xorout  = xo;
        cfg_residue = res;
        for (int i = 0; i < frm.size(); i++) begin
            drive_beat(frm[i], i == frm.size() - 1);
            if (garble && i == 0) begin
                cfg_width  = 5'd3;
                cfg_poly   = 16'hBEEF;
                cfg_init   = 16'h1234;
                cfg_xorout = 16'h00FF;
            end
        end
        chk("latency_out_valid", 32'(sif.out_valid), 32'd1);
        sif.in_valid = 1'b0;
        sif.in_last  = 1'b0;
    endtask

    logic        stall_prev = 1'b0;
    logic [15:0] held_crc;
    logic        held_ok;

    always @(negedge clk) begin
        if (rst_n && sif.out_valid) begin
            if (!sif.out_ready) begin
                chk("stall_in_ready", 32'(sif.in_ready), 32'd0);
                if (stall_prev) begin
                    chk("stall_crc_stable", 32'(sif.out_crc), 32'(held_crc));
                    chk("stall_ok_stable", 32'(sif.out_ok), 32'(held_ok));
                end
                stall_prev = 1'b1;
                held_crc   = sif.out_crc;
                held_ok    = sif.out_ok;
            end else begin
                stall_prev = 1'b0;
                if (sb_crc.size() == 0) begin
                    chk("unexpected_result", 32'(sif.out_crc), 32'hFFFF_FFFF);
                end else begin
                    chk("out_crc", 32'(sif.out_crc), 32'(sb_crc.pop_front()));
                    chk("out_ok", 32'(sif.out_ok), 32'(sb_ok.pop_front()));
                end
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        int n;
        sif.in_valid  = 1'b0;
        sif.in_data   = '0;
        sif.in_last   = 1'b0;
        sif.out_ready = 1'b1;
        #12;
        chk("rst_in_ready", 32'(sif.in_ready), 32'd1);
        chk("rst_out_valid", 32'(sif.out_valid), 32'd0);
        chk("rst_out_crc", 32'(sif.out_crc), 32'd0);
        chk("rst_out_ok", 32'(sif.out_ok), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        load_check_string();
        send_frame(5'd8, CRC8_SMBUS_POLY, 16'h0000, 16'h0000, 16'h0, 16'h00F4, 1'b0, 1'b0);
        send_frame(5'd16, CRC16_XMODEM_POLY, 16'h0000, 16'h0000, 16'h0, 16'h31C3, 1'b0, 1'b0);
        send_frame(5'd5, CRC5_EPC_POLY, CRC5_EPC_INIT, 16'h0000, 16'h0, 16'h0000, 1'b0, 1'b0);
        send_frame(5'd8, CRC8_SMBUS_POLY, 16'h0000, 16'h00FF, 16'h0, 16'h000B, 1'b0, 1'b0);
        send_frame(5'd8, CRC8_SMBUS_POLY, 16'h0000, 16'h0000, 16'h0, 16'h00F4, 1'b0, 1'b1);
        send_frame(5'd0, CRC16_XMODEM_POLY, 16'h0000, 16'h0000, 16'h0, 16'h31C3, 1'b0, 1'b0);
        send_frame(5'd20, CRC16_XMODEM_POLY, 16'h0000, 16'h0000, 16'h0, 16'h31C3, 1'b0, 1'b0);

        frm = {8'h00};
        send_frame(5'd8, CRC8_SMBUS_POLY, 16'h00FF, 16'h0000, 16'h0, 16'h00F3, 1'b0, 1'b0);

        // Two back-to-back frames with the result consumer stalled for three cycles.
        @(negedge clk);
        sif.out_ready = 1'b0;
        fork
            begin
                load_check_string();
                send_frame(5'd8, CRC8_SMBUS_POLY, 16'h0000, 16'h0000, 16'h0, 16'h00F4, 1'b0, 1'b0);
                send_frame(5'd16, CRC16_XMODEM_POLY, 16'h0000, 16'h0000, 16'h0, 16'h31C3, 1'b0, 1'b0);
            end
            begin
                n = 0;
                while (!sif.out_valid && n < 300) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 300) chk("stall_wait_timeout", 32'(n), 32'd0);
                repeat (3) @(negedge clk);
                sif.out_ready = 1'b1;
            end
        join

        // Partial frame abandoned by reset must not leak into the next frame.
        repeat (3) @(negedge clk);
        cfg_width = 5'd8; cfg_poly = CRC8_SMBUS_POLY; cfg_init = 16'h0; cfg_xorout = 16'h0;
        for (int i = 0; i < 4; i++) drive_beat(8'h31 + 8'(i), 1'b0);
        @(negedge clk);
        sif.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(sif.in_ready), 32'd1);
        chk("midrst_out_valid", 32'(sif.out_valid), 32'd0);
        chk("midrst_out_crc", 32'(sif.out_crc), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_frame(5'd8, CRC8_SMBUS_POLY, 16'h0000, 16'h0000, 16'h0, 16'h00F4, 1'b0, 1'b0);

`ifdef CRC_CHECK_EN
        frm = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};
        send_frame(5'd8, CRC8_SMBUS_POLY, 16'h0000, 16'h0000, 16'h0, 16'h0000, 1'b1, 1'b0);
        frm = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF5};
        send_frame(5'd8, CRC8_SMBUS_POLY, 16'h0000, 16'h0000, 16'h0, 16'h0007, 1'b0, 1'b0);
`endif

        n = 0;
        while (sb_crc.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("scoreboard_drained", 32'(sb_crc.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
